piece_mover: RTL and testbench
==============================

PIECE_MOVER -- requirements
Module: piece_mover

Interface
REQ-001 SHALL have parameter GRAVITY_DIV, default 8: clka cycles per one-row gravity step in FALL (legal 2..255).
REQ-002 SHALL have port clka  in  1  sole clock; all logic updates on the rising edge.
REQ-003 SHALL have port restart  in  1  reset; synchronous, active-high.
REQ-004 SHALL have port start  in  1  single-cycle request to spawn a new piece; honoured only in IDLE.
REQ-005 SHALL have port curr_piece  in  2  piece code, sampled with start.
REQ-006 SHALL have port board_in  in  32  settled board from the clear stage, sampled with start.
REQ-007 SHALL have ports left, right  in  1 each  lateral move requests, level-sensitive.
REQ-008 SHALL have port board_out  out  32  registered settled board OR falling-piece mask.
REQ-009 SHALL have port landed  out  1  one-cycle pulse when a piece merges.
REQ-010 SHALL have port game_over  out  1  sticky spawn-collision flag.
REQ-011 SHALL have port state  out  3  current FSM state encoding.

Function
REQ-012 SHALL map the board as 8 rows x 4 columns: cell (row r, column c) = bit 4r+c; row 0 = bits[3:0] top, row 7 = bits[31:28] bottom; column 0 = leftmost.
REQ-013 SHALL use spawn masks: 00 -> {1}; 01 -> {1,5}; 10 -> {1,2,5,6}; 11 -> {1,5,6}.
REQ-014 SHALL implement states IDLE=0, SPAWN=1, FALL=2, LAND=3, OVER=4.
REQ-015 IDLE: start=1 -> latch board_in into settled reg, load spawn mask for curr_piece, go SPAWN; start=0 -> stay.
REQ-016 SPAWN: (mask AND settled) != 0 -> set game_over, go OVER; else clear gravity counter, go FALL.
REQ-017 FALL: counter increments each cycle; at count GRAVITY_DIV-1 it wraps to 0 and a gravity step is attempted.
REQ-018 Gravity step: if the mask has no bit in row 7 and (mask<<4) AND settled == 0, mask <= mask<<4; else go LAND.
REQ-019 On non-gravity FALL cycles only: left=1, right=0 moves the mask one column left if no mask bit is in column 0 and the shifted mask does not hit settled; right symmetric for column 3; otherwise no change.
REQ-020 left=1 and right=1 together SHALL produce no lateral move; lateral requests are ignored on gravity cycles; at most one move per cycle.
REQ-021 LAND: settled <= settled OR mask, mask <= 0, landed=1 for exactly this cycle, go IDLE.
REQ-022 OVER: hold all registers; leave only on restart.
REQ-023 board_out SHALL equal settled OR mask as of the previous edge (one-cycle latency).
REQ-024 start outside IDLE SHALL be ignored.

Reset
REQ-025 restart=1 at an edge SHALL force state=IDLE, settled=0, mask=0, counter=0, board_out=0, landed=0, game_over=0, overriding every other input in any state, including mid-FALL.

Configuration
REQ-026 With HARD_DROP_EN defined, SHALL add port drop in 1: drop=1 in FALL makes every cycle a gravity cycle (one row per cycle, lateral ignored) until LAND; drop latched until LAND.
REQ-027 Without HARD_DROP_EN, the drop port SHALL not exist and gravity follows REQ-017 only.

Verification
REQ-028 restart, then start with curr_piece=00, board_in=0 -> IDLE->SPAWN->FALL; board_out=0x00000002; after 7 gravity steps (7*8 cycles) piece sits at bit 29, LAND: landed pulse, board_out=0x20000000.
REQ-029 curr_piece=10, board_in=0x00000002 -> SPAWN collision: game_over=1, state=4, held until restart.
REQ-030 curr_piece=00, left held on non-gravity cycles -> mask moves bit1->bit0 then stays at bit0 (column-0 wall); left+right together -> mask unchanged.
REQ-031 board_in=0xF0000000, curr_piece=11 -> piece lands resting on row 7; board_out=0xF6200000 and landed pulses once.
REQ-032 restart asserted mid-FALL -> next cycle state=0, board_out=0, landed=0, game_over=0.
REQ-033 (HARD_DROP_EN) curr_piece=00, board_in=0, drop=1 in first FALL cycle -> bottom reached in 7 consecutive cycles, LAND on the 8th.

Source files
------------

// File: rtl/piece_mover.sv
// rtl/piece_mover.sv - falling-piece controller for an 8x4 block board
// Optional HARD_DROP_EN adds a drop input that forces one gravity row per cycle.
module piece_mover #(
  parameter int GRAVITY_DIV = 8
) (
  input  logic        clka,
  input  logic        restart,
  input  logic        start,
  input  logic [1:0]  curr_piece,
  input  logic [31:0] board_in,
  input  logic        left,
  input  logic        right,
`ifdef HARD_DROP_EN
  input  logic        drop,
`endif
  output logic [31:0] board_out,
  output logic        landed,
  output logic        game_over,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SPAWN = 3'd1,
    S_FALL  = 3'd2,
    S_LAND  = 3'd3,
    S_OVER  = 3'd4
  } state_t;

  // Bit masks of the leftmost and rightmost columns across all eight rows.
  localparam logic [31:0] COL0_MASK = 32'h1111_1111;
  localparam logic [31:0] COL3_MASK = 32'h8888_8888;

  state_t      r_state;
  logic [31:0] r_settled;
  logic [31:0] r_mask;
  logic [7:0]  r_cnt;
  logic [31:0] r_board_out;
  logic        r_landed;
  logic        r_game_over;

  logic [31:0] w_spawn;
  logic [31:0] w_down;
  logic [31:0] w_left;
  logic [31:0] w_right;
  logic        w_can_down;
  logic        w_can_left;
  logic        w_can_right;
  logic        w_grav;

  always_comb begin
    w_spawn = 32'h0;
    case (curr_piece)
      2'b00:   w_spawn = 32'h0000_0002;
      2'b01:   w_spawn = 32'h0000_0022;
      2'b10:   w_spawn = 32'h0000_0066;
      default: w_spawn = 32'h0000_0062;
    endcase
  end

  assign w_down      = r_mask << 4;
  assign w_left      = r_mask >> 1;
  assign w_right     = r_mask << 1;
  assign w_can_down  = (r_mask[31:28] == 4'h0) && ((w_down & r_settled) == 32'h0);
  assign w_can_left  = ((r_mask & COL0_MASK) == 32'h0) && ((w_left & r_settled) == 32'h0);
  assign w_can_right = ((r_mask & COL3_MASK) == 32'h0) && ((w_right & r_settled) == 32'h0);

`ifdef HARD_DROP_EN
  logic r_drop;
  assign w_grav = (r_cnt == 8'(GRAVITY_DIV - 1)) || drop || r_drop;
`else
  assign w_grav = (r_cnt == 8'(GRAVITY_DIV - 1));
`endif

  always_ff @(posedge clka) begin
    if (restart) begin
      r_state     <= S_IDLE;
      r_settled   <= 32'h0;
      r_mask      <= 32'h0;
      r_cnt       <= 8'h0;
      r_board_out <= 32'h0;
      r_landed    <= 1'b0;
      r_game_over <= 1'b0;
`ifdef HARD_DROP_EN
      r_drop      <= 1'b0;
`endif
    end else begin
      r_board_out <= r_settled | r_mask;
      r_landed    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_settled <= board_in;
            r_mask    <= w_spawn;
            r_state   <= S_SPAWN;
          end
        end
        S_SPAWN: begin
          if ((r_mask & r_settled) != 32'h0) begin
            r_game_over <= 1'b1;
            r_state     <= S_OVER;
          end else begin
            r_cnt   <= 8'h0;
            r_state <= S_FALL;
          end
        end
        S_FALL: begin
`ifdef HARD_DROP_EN
          if (drop) r_drop <= 1'b1;
`endif
          if (w_grav) begin
            r_cnt <= 8'h0;
            if (w_can_down) begin
              r_mask <= w_down;
            end else begin
              // landed is raised on entry so it is high exactly while state is LAND
              r_state  <= S_LAND;
              r_landed <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 8'h1;
            if (left && !right && w_can_left) begin
              r_mask <= w_left;
            end else if (right && !left && w_can_right) begin
              r_mask <= w_right;
            end
          end
        end
        S_LAND: begin
          r_settled <= r_settled | r_mask;
          r_mask    <= 32'h0;
          r_state   <= S_IDLE;
`ifdef HARD_DROP_EN
          r_drop    <= 1'b0;
`endif
        end
        S_OVER: begin
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign board_out = r_board_out;
  assign landed    = r_landed;
  assign game_over = r_game_over;
  assign state     = r_state;

endmodule

// File: tb/tb_piece_mover.sv
// tb/tb_piece_mover.sv - randomized self-checking bench for piece_mover
// Reference model tracks the board as an 8x4 cell grid and the piece as a cell list.
module tb_piece_mover;

  localparam int GDIV = 8;

  logic        clka = 1'b0;
  logic        restart = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  curr_piece = 2'b00;
  logic [31:0] board_in = 32'h0;
  logic        tb_left = 1'b0;
  logic        tb_right = 1'b0;
  logic [31:0] board_out;
  logic        landed;
  logic        game_over;
  logic [2:0]  state;
`ifdef HARD_DROP_EN
  logic        tb_drop = 1'b0;
`endif

  int n_tests = 0;
  int n_fail = 0;

  piece_mover #(.GRAVITY_DIV(GDIV)) dut (
    .clka(clka),
    .restart(restart),
    .start(start),
    .curr_piece(curr_piece),
    .board_in(board_in),
    .left(tb_left),
    .right(tb_right),
`ifdef HARD_DROP_EN
    .drop(tb_drop),
`endif
    .board_out(board_out),
    .landed(landed),
    .game_over(game_over),
    .state(state)
  );

  always #5 clka = ~clka;

  int          m_state = 0;
  bit          m_grid[8][4];
  int          m_n = 0;
  int          m_r[4];
  int          m_c[4];
  int          m_cnt = 0;
  logic [31:0] m_bo = 32'h0;
  bit          m_landed = 0;
  bit          m_go = 0;

  function automatic logic [31:0] model_board();
    logic [31:0] b;
    b = 32'h0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 4; c++)
        if (m_grid[r][c]) b[4*r+c] = 1'b1;
    for (int i = 0; i < m_n; i++) b[4*m_r[i]+m_c[i]] = 1'b1;
    return b;
  endfunction

  function automatic logic [36:0] exp_vec();
    return {m_state[2:0], m_bo, m_landed, m_go};
  endfunction

  task automatic add_cell(input int r, input int c);
    m_r[m_n] = r;
    m_c[m_n] = c;
    m_n++;
  endtask

  task automatic model_edge(input bit st, input logic [1:0] pc, input logic [31:0] bi,
                            input bit l, input bit rt, input bit rs);
    logic [31:0] prev;
    bit ok;
    prev = model_board();
    m_landed = 0;
    if (rs) begin
      m_state = 0; m_n = 0; m_cnt = 0; m_bo = 32'h0; m_go = 0;
      for (int r = 0; r < 8; r++) for (int c = 0; c < 4; c++) m_grid[r][c] = 0;
    end else begin
      m_bo = prev;
      case (m_state)
        0: if (st) begin
          for (int r = 0; r < 8; r++) for (int c = 0; c < 4; c++) m_grid[r][c] = bi[4*r+c];
          m_n = 0;
          add_cell(0, 1);
          if (pc != 2'b00) add_cell(1, 1);
          if (pc == 2'b10) begin add_cell(0, 2); add_cell(1, 2); end
          if (pc == 2'b11) add_cell(1, 2);
          m_state = 1;
        end
        1: begin
          ok = 1;
          for (int i = 0; i < m_n; i++) if (m_grid[m_r[i]][m_c[i]]) ok = 0;
          if (!ok) begin m_go = 1; m_state = 4; end
          else begin m_cnt = 0; m_state = 2; end
        end
        2: begin
          if (m_cnt == GDIV - 1) begin
            m_cnt = 0;
            ok = 1;
            for (int i = 0; i < m_n; i++) begin
              if (m_r[i] == 7) ok = 0;
              else if (m_grid[m_r[i]+1][m_c[i]]) ok = 0;
            end
            if (ok) for (int i = 0; i < m_n; i++) m_r[i]++;
            else begin m_state = 3; m_landed = 1; end
          end else begin
            m_cnt++;
            if (l && !rt) begin
              ok = 1;
              for (int i = 0; i < m_n; i++) begin
                if (m_c[i] == 0) ok = 0;
                else if (m_grid[m_r[i]][m_c[i]-1]) ok = 0;
              end
              if (ok) for (int i = 0; i < m_n; i++) m_c[i]--;
            end else if (rt && !l) begin
              ok = 1;
              for (int i = 0; i < m_n; i++) begin
                if (m_c[i] == 3) ok = 0;
                else if (m_grid[m_r[i]][m_c[i]+1]) ok = 0;
              end
              if (ok) for (int i = 0; i < m_n; i++) m_c[i]++;
            end
          end
        end
        3: begin
          for (int i = 0; i < m_n; i++) m_grid[m_r[i]][m_c[i]] = 1;
          m_n = 0;
          m_state = 0;
        end
        default: ;
      endcase
    end
  endtask

  // Drives one cycle of inputs, advances the model at the edge, returns 1ns after it.
  task automatic step(input bit st, input logic [1:0] pc, input logic [31:0] bi,
                      input bit l, input bit rt, input bit rs);
    start = st; curr_piece = pc; board_in = bi;
    tb_left = l; tb_right = rt; restart = rs;
    @(posedge clka);
    model_edge(st, pc, bi, l, rt, rs);
    #1;
    start = 1'b0; restart = 1'b0; tb_left = 1'b0; tb_right = 1'b0;
  endtask

  task automatic test_reset();
    step(0, 2'b00, 32'h0, 0, 0, 1);
    n_tests++;
    if ({state, board_out, landed, game_over} !== 37'h0) begin
      n_fail++;
      $display("FAIL reset_state act=%h exp=%h", {state, board_out, landed, game_over}, 37'h0);
    end
    step(0, 2'b00, 32'h0, 0, 0, 0);
    n_tests++;
    if ({state, board_out, landed, game_over} !== exp_vec()) begin
      n_fail++;
      $display("FAIL reset_idle act=%h exp=%h", {state, board_out, landed, game_over}, exp_vec());
    end
  endtask

  task automatic test_fall_basic();
    int nland, nfall;
    logic [31:0] land_bo;
    bit done;
    nland = 0; nfall = 0; land_bo = 32'h0; done = 0;
    step(0, 2'b00, 32'h0, 0, 0, 1);
    step(1, 2'b00, 32'h0, 0, 0, 0);
    n_tests++;
    if (state !== 3'd1) begin n_fail++; $display("FAIL basic_spawn act=%0d exp=1", state); end
    step(0, 2'b00, 32'h0, 0, 0, 0);
    n_tests++;
    if (board_out !== 32'h0000_0002) begin
      n_fail++; $display("FAIL basic_first_fall act=%h exp=00000002", board_out);
    end
    if (state == 3'd2) nfall++;
    for (int k = 0; k < 200 && !done; k++) begin
      step(0, 2'b00, 32'h0, 0, 0, 0);
      n_tests++;
      if ({state, board_out, landed, game_over} !== exp_vec()) begin
        n_fail++;
        $display("FAIL basic_cycle act=%h exp=%h", {state, board_out, landed, game_over}, exp_vec());
      end
      if (state == 3'd2) nfall++;
      if (landed) begin nland++; land_bo = board_out; end
      if (state == 3'd0) done = 1;
    end
    n_tests++;
    if (!done) begin n_fail++; $display("FAIL basic_timeout act=%0d exp=0", state); end
    n_tests++;
    if (nland != 1) begin n_fail++; $display("FAIL basic_landed_count act=%0d exp=1", nland); end
    n_tests++;
    if (land_bo !== 32'h2000_0000) begin
      n_fail++; $display("FAIL basic_land_board act=%h exp=20000000", land_bo);
    end
    n_tests++;
    if (nfall != 8 * GDIV) begin
      n_fail++; $display("FAIL basic_fall_cycles act=%0d exp=%0d", nfall, 8 * GDIV);
    end
  endtask

  task automatic test_collision();
    step(0, 2'b00, 32'h0, 0, 0, 1);
    step(1, 2'b10, 32'h0000_0002, 0, 0, 0);
    step(0, 2'b00, 32'h0, 0, 0, 0);
    n_tests++;
    if ({state, game_over} !== {3'd4, 1'b1}) begin
      n_fail++; $display("FAIL collide_over act=%0d/%0d exp=4/1", state, game_over);
    end
    for (int k = 0; k < 10; k++) begin
      step(k[0], 2'b00, 32'h0, k[1], 0, 0);
      n_tests++;
      if ({state, board_out, landed, game_over} !== exp_vec() || state !== 3'd4) begin
        n_fail++;
        $display("FAIL collide_hold act=%h exp=%h", {state, board_out, landed, game_over}, exp_vec());
      end
    end
    step(0, 2'b00, 32'h0, 0, 0, 1);
    n_tests++;
    if ({state, game_over} !== 4'h0) begin
      n_fail++; $display("FAIL collide_restart act=%0d/%0d exp=0/0", state, game_over);
    end
  endtask

  task automatic test_lateral();
    bit done;
    done = 0;
    step(0, 2'b00, 32'h0, 0, 0, 1);
    step(1, 2'b00, 32'h0, 0, 0, 0);
    step(0, 2'b00, 32'h0, 0, 0, 0);
    step(0, 2'b00, 32'h0, 1, 0, 0);
    step(0, 2'b00, 32'h0, 1, 0, 0);
    step(0, 2'b00, 32'h0, 0, 0, 0);
    n_tests++;
    if (board_out !== 32'h0000_0001) begin
      n_fail++; $display("FAIL lateral_wall act=%h exp=00000001", board_out);
    end
    step(0, 2'b00, 32'h0, 1, 1, 0);
    step(0, 2'b00, 32'h0, 1, 1, 0);
    step(0, 2'b00, 32'h0, 0, 0, 0);
    n_tests++;
    if (board_out !== 32'h0000_0001) begin
      n_fail++; $display("FAIL lateral_both act=%h exp=00000001", board_out);
    end
    for (int k = 0; k < 200 && !done; k++) begin
      step(0, 2'b00, 32'h0, 0, k % 5 == 0, 0);
      n_tests++;
      if ({state, board_out, landed, game_over} !== exp_vec()) begin
        n_fail++;
        $display("FAIL lateral_cycle act=%h exp=%h", {state, board_out, landed, game_over}, exp_vec());
      end
      if (state == 3'd0) done = 1;
    end
    n_tests++;
    if (!done) begin n_fail++; $display("FAIL lateral_timeout act=%0d exp=0", state); end
  endtask

  task automatic test_stack();
    int nland;
    logic [31:0] land_bo;
    bit done;
    nland = 0; land_bo = 32'h0; done = 0;
    step(0, 2'b00, 32'h0, 0, 0, 1);
    step(1, 2'b11, 32'hF000_0000, 0, 0, 0);
    for (int k = 0; k < 200 && !done; k++) begin
      step(0, 2'b00, 32'h0, 0, 0, 0);
      n_tests++;
      if ({state, board_out, landed, game_over} !== exp_vec()) begin
        n_fail++;
        $display("FAIL stack_cycle act=%h exp=%h", {state, board_out, landed, game_over}, exp_vec());
      end
      if (landed) begin nland++; land_bo = board_out; end
      if (state == 3'd0) done = 1;
    end
    step(0, 2'b00, 32'h0, 0, 0, 0);
    n_tests++;
    if (!done || nland != 1) begin
      n_fail++; $display("FAIL stack_landed act=%0d exp=1", nland);
    end
    n_tests++;
    if (land_bo !== 32'hF620_0000 || board_out !== 32'hF620_0000) begin
      n_fail++; $display("FAIL stack_board act=%h/%h exp=f6200000", land_bo, board_out);
    end
  endtask

  task automatic test_restart_mid();
    step(0, 2'b00, 32'h0, 0, 0, 1);
    step(1, 2'b01, 32'h0, 0, 0, 0);
    for (int k = 0; k < 20; k++) step(0, 2'b00, 32'h0, $urandom_range(0, 1), $urandom_range(0, 1), 0);
    n_tests++;
    if (state !== 3'd2) begin n_fail++; $display("FAIL midfall_pre act=%0d exp=2", state); end
    step(1, 2'b10, 32'hFFFF_FFFF, 1, 0, 1);
    n_tests++;
    if ({state, board_out, landed, game_over} !== 37'h0) begin
      n_fail++;
      $display("FAIL midfall_restart act=%h exp=%h", {state, board_out, landed, game_over}, 37'h0);
    end
  endtask

  task automatic test_random();
    logic [31:0] bi;
    bit rs;
    step(0, 2'b00, 32'h0, 0, 0, 1);
    for (int k = 0; k < 3000; k++) begin
      bi = $urandom & $urandom;
      if ($urandom_range(0, 2) != 0) bi = bi & 32'hFFFF_FF00;
      rs = ($urandom_range(0, 199) == 0) || (m_state == 4 && $urandom_range(0, 4) == 0);
      step($urandom_range(0, 3) == 0, 2'($urandom_range(0, 3)), bi,
           $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, rs);
      n_tests++;
      if ({state, board_out, landed, game_over} !== exp_vec()) begin
        n_fail++;
        $display("FAIL random_cycle%0d act=%h exp=%h", k, {state, board_out, landed, game_over}, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_fall_basic();
    test_collision();
    test_lateral();
    test_stack();
    test_restart_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
